// File: rtl/conv_window_gen.sv
// 5x5 sliding-window generator over a raster pixel stream, using four line buffers.
// Define CONV_WINDOW_FRAME_DONE_EN to add the frame_done pulse output.
module conv_window_gen #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] pixel_in,
  input  logic                     valid_in,
  output logic signed [DATA_W-1:0] data_out_0,
  output logic signed [DATA_W-1:0] data_out_1,
  output logic signed [DATA_W-1:0] data_out_2,
  output logic signed [DATA_W-1:0] data_out_3,
  output logic signed [DATA_W-1:0] data_out_4,
  output logic signed [DATA_W-1:0] data_out_5,
  output logic signed [DATA_W-1:0] data_out_6,
  output logic signed [DATA_W-1:0] data_out_7,
  output logic signed [DATA_W-1:0] data_out_8,
  output logic signed [DATA_W-1:0] data_out_9,
  output logic signed [DATA_W-1:0] data_out_10,
  output logic signed [DATA_W-1:0] data_out_11,
  output logic signed [DATA_W-1:0] data_out_12,
  output logic signed [DATA_W-1:0] data_out_13,
  output logic signed [DATA_W-1:0] data_out_14,
  output logic signed [DATA_W-1:0] data_out_15,
  output logic signed [DATA_W-1:0] data_out_16,
  output logic signed [DATA_W-1:0] data_out_17,
  output logic signed [DATA_W-1:0] data_out_18,
  output logic signed [DATA_W-1:0] data_out_19,
  output logic signed [DATA_W-1:0] data_out_20,
  output logic signed [DATA_W-1:0] data_out_21,
  output logic signed [DATA_W-1:0] data_out_22,
  output logic signed [DATA_W-1:0] data_out_23,
  output logic signed [DATA_W-1:0] data_out_24,
`ifdef CONV_WINDOW_FRAME_DONE_EN
  output logic                     frame_done,
`endif
  output logic                     valid_out_buf
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          vld_q, vld_d;
  logic signed [DATA_W-1:0] win_q  [25];
  logic signed [DATA_W-1:0] lb_q   [4][IMG_W];
  logic signed [DATA_W-1:0] col_in [5];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    vld_d = valid_in && (row_q >= RW'(4)) && (col_q >= CW'(4));
    if (valid_in) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Incoming column, oldest row (r-4) at index 0, current pixel at index 4.
  always_comb begin
    col_in[0] = lb_q[3][col_q];
    col_in[1] = lb_q[2][col_q];
    col_in[2] = lb_q[1][col_q];
    col_in[3] = lb_q[0][col_q];
    col_in[4] = pixel_in;
  end

  // Line buffers carry no reset so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb_q[0][col_q] <= pixel_in;
      lb_q[1][col_q] <= lb_q[0][col_q];
      lb_q[2][col_q] <= lb_q[1][col_q];
      lb_q[3][col_q] <= lb_q[2][col_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      vld_q <= 1'b0;
      for (int k = 0; k < 25; k++) win_q[k] <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      vld_q <= vld_d;
      if (valid_in) begin
        for (int i = 0; i < 5; i++) begin
          for (int j = 0; j < 4; j++) win_q[5*i+j] <= win_q[5*i+j+1];
          win_q[5*i+4] <= col_in[i];
        end
      end
    end
  end

`ifdef CONV_WINDOW_FRAME_DONE_EN
  logic fd_q, fd_d;

  always_comb fd_d = valid_in && (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fd_q <= 1'b0;
    else     fd_q <= fd_d;
  end

  assign frame_done = fd_q;
`endif

  assign valid_out_buf = vld_q;
  assign data_out_0  = win_q[0];
  assign data_out_1  = win_q[1];
  assign data_out_2  = win_q[2];
  assign data_out_3  = win_q[3];
  assign data_out_4  = win_q[4];
  assign data_out_5  = win_q[5];
  assign data_out_6  = win_q[6];
  assign data_out_7  = win_q[7];
  assign data_out_8  = win_q[8];
  assign data_out_9  = win_q[9];
  assign data_out_10 = win_q[10];
  assign data_out_11 = win_q[11];
  assign data_out_12 = win_q[12];
  assign data_out_13 = win_q[13];
  assign data_out_14 = win_q[14];
  assign data_out_15 = win_q[15];
  assign data_out_16 = win_q[16];
  assign data_out_17 = win_q[17];
  assign data_out_18 = win_q[18];
  assign data_out_19 = win_q[19];
  assign data_out_20 = win_q[20];
  assign data_out_21 = win_q[21];
  assign data_out_22 = win_q[22];
  assign data_out_23 = win_q[23];
  assign data_out_24 = win_q[24];

endmodule
